// File: rtl/key_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_load_ctrl
// Description : Word-serial loader for a logic-locked core's key. It publishes
//               KEY and enables the core only after a complete load. Defining
//               KEYCTL_CHECK_EN adds a trailing XOR-checksum beat before the
//               key is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module key_load_ctrl #(
    parameter int KEY_W  = 64,
    parameter int WORD_W = 8
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic              START,
    input  logic              CLEAR_KEY,
    input  logic [WORD_W-1:0] S_DATA,
    input  logic              S_VALID,
    output logic              S_READY,
    output logic [KEY_W-1:0]  KEY,
    output logic              KEY_VALID,
    output logic              CORE_EN,
    output logic              BUSY,
    output logic              ERR
);

    localparam int c_beats = KEY_W / WORD_W;
    localparam int c_cnt_w = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_beats - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [KEY_W-1:0]   r_shadow;
    logic [KEY_W-1:0]   r_key;
    logic [KEY_W-1:0]   w_shadow_nxt;
    logic               w_beat;
`ifdef KEYCTL_CHECK_EN
    logic [WORD_W-1:0]  r_chk;
`endif

    // Shadow including the word accepted this cycle, so DONE sees the full key.
    always_comb begin
        w_shadow_nxt = r_shadow;
        w_shadow_nxt[int'(r_cnt)*WORD_W +: WORD_W] = S_DATA;
    end

    assign w_beat = S_VALID & S_READY;

    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_key    <= '0;
`ifdef KEYCTL_CHECK_EN
            r_chk    <= '0;
`endif
        end else if (CLEAR_KEY) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_key    <= '0;
`ifdef KEYCTL_CHECK_EN
            r_chk    <= '0;
`endif
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_beat) begin
                        r_shadow <= w_shadow_nxt;
`ifdef KEYCTL_CHECK_EN
                        r_chk    <= r_chk ^ S_DATA;
`endif
                        if (r_cnt == c_last) begin
`ifdef KEYCTL_CHECK_EN
                            r_state <= ST_CHECK;
`else
                            r_state <= ST_DONE;
                            r_key   <= w_shadow_nxt;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
`ifdef KEYCTL_CHECK_EN
                ST_CHECK: begin
                    if (w_beat) begin
                        if (S_DATA == r_chk) begin
                            r_state <= ST_DONE;
                            r_key   <= r_shadow;
                        end else begin
                            r_state <= ST_ERROR;
                        end
                    end
                end
`endif
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    // Any (re)load starts from a clean slate; the core loses its key at once.
                    if (START) begin
                        r_state  <= ST_LOAD;
                        r_cnt    <= '0;
                        r_shadow <= '0;
                        r_key    <= '0;
`ifdef KEYCTL_CHECK_EN
                        r_chk    <= '0;
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_key   <= '0;
                end
            endcase
        end
    end

    assign KEY       = r_key;
    assign S_READY   = (r_state == ST_LOAD) || (r_state == ST_CHECK);
    assign BUSY      = (r_state == ST_LOAD) || (r_state == ST_CHECK);
    assign KEY_VALID = (r_state == ST_DONE);
    assign CORE_EN   = (r_state == ST_DONE);
`ifdef KEYCTL_CHECK_EN
    assign ERR       = (r_state == ST_ERROR);
`else
    assign ERR       = 1'b0;
`endif

endmodule
`default_nettype wire
